// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: device completion / core handshake bundle for the interrupt arbiter
interface irq_arbiter_if #(parameter int OVF_W = 8);
  logic             done1, done2, done3, done4;
  logic             int_ack, eoi, mask_we;
  logic [3:0]       mask_in;
  logic             irq, busy;
  logic [31:0]      int_addr;
  logic [1:0]       cur_id;
  logic [3:0]       pending, mask;
  logic [OVF_W-1:0] overrun;
  modport master (
    output done1, done2, done3, done4, int_ack, eoi, mask_we, mask_in,
    input  irq, int_addr, cur_id, busy, pending, mask, overrun
  );
  modport slave (
    input  done1, done2, done3, done4, int_ack, eoi, mask_we, mask_in,
    output irq, int_addr, cur_id, busy, pending, mask, overrun
  );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: four-source edge-latched interrupt arbiter with fixed priority, masking and overrun count
module irq_arbiter #(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_01F0,
  parameter int          OVF_W       = 8
) (
  input logic           clk,
  input logic           reset,
  irq_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_nx;
  logic [3:0] done_v, done_q, edges, clr, lost, sel;
  logic [1:0] low;
  logic [2:0] lost_n;
  logic [OVF_W+1:0] ovf_sum;
  assign done_v  = {bus.done4, bus.done3, bus.done2, bus.done1};
  assign edges   = done_v & ~done_q;
  assign clr     = (state == REQ && bus.int_ack) ? 4'b0001 << bus.cur_id : 4'b0000;
  assign lost    = edges & bus.pending & ~clr;
  assign lost_n  = 3'(lost[0]) + 3'(lost[1]) + 3'(lost[2]) + 3'(lost[3]);
  assign ovf_sum = {2'b00, bus.overrun} + (OVF_W+2)'(lost_n);
  assign sel     = bus.pending & ~bus.mask;
  assign low     = sel[0] ? 2'd0 : sel[1] ? 2'd1 : sel[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (|sel ? REQ : IDLE) :
               state == REQ  ? (bus.int_ack ? SERVICE : REQ) :
                               (bus.eoi ? IDLE : SERVICE);
  end
  always_comb begin
    bus.irq      = state == REQ;
    bus.busy     = state != IDLE;
    bus.int_addr = VECTOR_BASE + {28'd0, bus.cur_id, 2'b00};
  end
  // set beats clear, so an edge landing on the acknowledge cycle is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= '0;
      bus.pending <= '0;
      bus.mask    <= '0;
      bus.overrun <= '0;
      bus.cur_id  <= '0;
    end else begin
      done_q      <= done_v;
      bus.pending <= (bus.pending & ~clr) | edges;
      bus.mask    <= bus.mask_we ? bus.mask_in : bus.mask;
      bus.overrun <= ovf_sum > {2'b00, {OVF_W{1'b1}}} ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
      bus.cur_id  <= (state == IDLE && |sel) ? low : bus.cur_id;
    end
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed and random stimulus checked against a cycle-level behavioural model
module tb_irq_arbiter;
  logic clk, reset;
  int   errors, checks;
  int   ms, mcur, mo;
  bit   mp[4], mm[4], mprev[4];
  irq_arbiter_if #(.OVF_W(8)) bus();
  irq_arbiter #(.VECTOR_BASE(32'h0000_01F0), .OVF_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] pack(input bit v[4]);
    return {v[3], v[2], v[1], v[0]};
  endfunction
  task automatic model(input logic [3:0] d, input logic ack, input logic e, input logic we,
                       input logic [3:0] mi, input logic rst);
    int lostc, pick;
    bit np[4];
    if (rst) begin
      ms = 0; mcur = 0; mo = 0;
      for (int i = 0; i < 4; i++) begin mp[i] = 0; mm[i] = 0; mprev[i] = 0; end
      return;
    end
    lostc = 0;
    for (int i = 0; i < 4; i++) begin
      bit ed, cl;
      ed = d[i] && !mprev[i];
      cl = ms == 1 && ack && mcur == i;
      if (ed && mp[i] && !cl) lostc++;
      np[i] = ed || (mp[i] && !cl);
    end
    pick = -1;
    for (int i = 3; i >= 0; i--) if (mp[i] && !mm[i]) pick = i;
    if (ms == 0 && pick >= 0) begin ms = 1; mcur = pick; end
    else if (ms == 1 && ack) ms = 2;
    else if (ms == 2 && e) ms = 0;
    mo = (mo + lostc > 255) ? 255 : mo + lostc;
    for (int i = 0; i < 4; i++) begin
      if (we) mm[i] = mi[i];
      mp[i] = np[i];
      mprev[i] = d[i];
    end
  endtask
  task automatic step(input logic [3:0] d, input logic ack = 0, input logic e = 0,
                      input logic we = 0, input logic [3:0] mi = 0, input logic rst = 0);
    {bus.done4, bus.done3, bus.done2, bus.done1} = d;
    bus.int_ack = ack; bus.eoi = e; bus.mask_we = we; bus.mask_in = mi; reset = rst;
    @(posedge clk);
    model(d, ack, e, we, mi, rst);
    #1;
    check("irq", bus.irq, ms == 1);
    check("busy", bus.busy, ms != 0);
    check("cur_id", bus.cur_id, mcur);
    check("int_addr", bus.int_addr, 32'h1F0 + 4 * mcur);
    check("pending", bus.pending, pack(mp));
    check("mask", bus.mask, pack(mm));
    check("overrun", bus.overrun, mo);
  endtask
  initial begin
    errors = 0; checks = 0;
    step(4'b0000, .rst(1)); step(4'b0000, .rst(1));
    check("rst_addr", bus.int_addr, 32'h1F0);
    check("rst_busy", bus.busy, 0);
    // single source
    step(4'b0100);
    check("s_pend", bus.pending, 4'b0100); check("s_irq0", bus.irq, 0);
    step(4'b0000);
    check("s_irq", bus.irq, 1); check("s_addr", bus.int_addr, 32'h1F8);
    step(4'b0000, .ack(1));
    check("s_ack_pend", bus.pending, 0); check("s_ack_busy", bus.busy, 1);
    step(4'b0000, .e(1));
    check("s_eoi_busy", bus.busy, 0);
    // priority, plus ignored ack/eoi outside their states
    step(4'b1010, .ack(1), .e(1));
    step(4'b0000);
    check("p_id", bus.cur_id, 1); check("p_addr", bus.int_addr, 32'h1F4);
    step(4'b0000, .ack(1)); step(4'b0000, .e(1)); step(4'b0000);
    check("p_id2", bus.cur_id, 3); check("p_addr2", bus.int_addr, 32'h1FC);
    step(4'b0000, .ack(1)); step(4'b0000, .e(1));
    // mask
    step(4'b0000, .we(1), .mi(4'b0001));
    step(4'b0001); step(4'b0000); step(4'b0000);
    check("m_pend", bus.pending, 4'b0001); check("m_irq", bus.irq, 0);
    step(4'b0000, .we(1), .mi(4'b0000)); step(4'b0000);
    check("m_irq1", bus.irq, 1); check("m_addr", bus.int_addr, 32'h1F0);
    // overrun and saturation
    step(4'b0000); step(4'b0001); step(4'b0000); step(4'b0001); step(4'b0000);
    check("o_two", bus.overrun, 2);
    for (int i = 0; i < 300; i++) begin step(4'b0001); step(4'b0000); end
    check("o_sat", bus.overrun, 255);
    step(4'b0000, .ack(1)); step(4'b0000, .e(1));
    // set wins over int_ack clear
    step(4'b0000, .rst(1));
    step(4'b0001); step(4'b0000); step(4'b0001, .ack(1));
    check("sw_pend", bus.pending, 4'b0001);
    step(4'b0000); step(4'b0000, .e(1)); step(4'b0000);
    check("sw_irq", bus.irq, 1); check("sw_addr", bus.int_addr, 32'h1F0);
    step(4'b0000, .ack(1)); step(4'b0000, .e(1));
    // reset mid-SERVICE with done4 held high
    step(4'b1000); step(4'b1000); step(4'b1000, .ack(1));
    check("r_busy_pre", bus.busy, 1);
    step(4'b1000, .e(1), .we(1), .mi(4'b1111), .rst(1));
    check("r_busy", bus.busy, 0); check("r_irq", bus.irq, 0); check("r_pend", bus.pending, 0);
    check("r_mask", bus.mask, 0); check("r_id", bus.cur_id, 0); check("r_addr", bus.int_addr, 32'h1F0);
    step(4'b1000); step(4'b1000);
    check("r_addr4", bus.int_addr, 32'h1FC); check("r_irq4", bus.irq, 1);
    step(4'b1000, .ack(1)); step(4'b1000, .e(1)); step(4'b1000); step(4'b1000);
    check("r_once", bus.busy, 0);
    // random traffic
    for (int i = 0; i < 2000; i++)
      step(4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter VECTOR_BASE, default 32'h0000_01F0, SHALL be the byte address of the source-0 vector slot.
REQ-002 Parameter OVF_W, default 8, SHALL be the overrun counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset, sampled only on posedge clk.
REQ-005 done1, done2, done3, done4  input  1 each  SHALL be the device completion lines for sources 0..3; done1 has the highest priority.
REQ-006 int_ack  input  1  SHALL be the core's interrupt-taken pulse.
REQ-007 eoi  input  1  SHALL be the end-of-interrupt pulse, asserted when JEPC retires.
REQ-008 mask_we  input  1  SHALL be the mask register write enable.
REQ-009 mask_in  input  4  SHALL be the mask write data; bit i=1 disables source i.
REQ-010 irq  output  1  SHALL be the registered interrupt request to the core.
REQ-011 int_addr  output  32  SHALL be the vector address for the selected source.
REQ-012 cur_id  output  2  SHALL be the index of the selected or in-service source.
REQ-013 busy  output  1  SHALL be 1 in states REQ and SERVICE.
REQ-014 pending  output  4  SHALL be the pending-event register.
REQ-015 mask  output  4  SHALL be the mask register.
REQ-016 overrun  output  OVF_W  SHALL be the count of lost events.

Function
REQ-017 Each done line SHALL be rising-edge detected against a one-cycle-delayed copy; an edge sets the matching pending bit on the next posedge.
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ and SERVICE.
REQ-019 In IDLE, when (pending & ~mask) != 0, the FSM SHALL latch cur_id = lowest set index and move to REQ.
REQ-020 irq SHALL be 1 exactly while in REQ, so it first rises one cycle after the pending bit is visible.
REQ-021 int_addr SHALL equal VECTOR_BASE + {cur_id, 2'b00} at all times; with the default VECTOR_BASE the values are 0x1F0, 0x1F4, 0x1F8 and 0x1FC.
REQ-022 In REQ with int_ack=1, pending[cur_id] SHALL clear and the FSM SHALL move to SERVICE.
REQ-023 In REQ with int_ack=0, the FSM SHALL hold; cur_id SHALL NOT change even if a higher-priority bit becomes pending.
REQ-024 In SERVICE, eoi=1 SHALL return the FSM to IDLE; no new selection occurs in the same cycle.
REQ-025 int_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-026 A mask write SHALL take effect on the next posedge.
REQ-027 Masking SHALL only gate selection in IDLE; it does not cancel REQ or SERVICE.
REQ-028 Masked pending bits SHALL be retained.
REQ-029 If an edge arrives on source i in the same cycle that pending[i] is cleared by int_ack, pending[i] SHALL end at 1 (set wins).
REQ-030 If an edge arrives on source i while pending[i] is already 1 and not being cleared, overrun SHALL increment by one per lost edge.
REQ-031 If lost edges occur on several sources in the same cycle, overrun SHALL add the number of lost edges.
REQ-032 overrun SHALL saturate at all-ones; it never wraps.
REQ-033 A line held high SHALL produce exactly one edge.
REQ-034 Edges during REQ and SERVICE SHALL be recorded normally.

Reset
REQ-035 On reset=1 at a posedge, the FSM SHALL go to IDLE, regardless of current state.
REQ-036 On reset=1 at a posedge, irq=0, cur_id=0, busy=0, pending=0, mask=0 and overrun=0.
REQ-037 On reset=1 at a posedge, edge-history registers SHALL clear to 0, so a line high on the first cycle after reset produces one edge.
REQ-038 Reset SHALL override int_ack, eoi, mask_we and done edges in the same cycle.
REQ-039 int_addr SHALL read VECTOR_BASE (0x1F0) while and after reset until a new selection.

Verification
REQ-040 Single source: pulse done3 for 1 cycle -> pending=4'b0100 at the next edge; irq=1 and int_addr=0x1F8 one cycle later; int_ack -> pending=0 and busy held; eoi -> IDLE, busy=0.
REQ-041 Priority: done2 and done4 rise together -> cur_id=1 and int_addr=0x1F4; after int_ack and eoi -> cur_id=3 and int_addr=0x1FC.
REQ-042 Mask: write mask=4'b0001, then pulse done1 -> pending=4'b0001 and irq stays 0; write mask=0 -> irq=1 with int_addr=0x1F0.
REQ-043 Overrun: three done1 pulses before int_ack -> overrun=2; 300 lost edges -> overrun=255.
REQ-044 Set-wins: done1 edge lands in the int_ack cycle for cur_id=0 -> pending[0]=1; after eoi -> irq reasserts with int_addr=0x1F0.
REQ-045 Reset mid-SERVICE, with done4 held high -> all outputs return to reset values; after reset drops, exactly one new request occurs, int_addr=0x1FC.
